// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 memory responder backed by a word-addressed RAM
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   S_AXI_AW*           write address channel (ID/ADDR/LEN/SIZE/BURST, VALID/READY)
//   S_AXI_W*            write data channel (DATA/STRB/LAST, VALID/READY)
//   S_AXI_B*            write response channel (ID/RESP, VALID/READY)
//   S_AXI_AR*           read address channel (ID/ADDR/LEN/SIZE/BURST, VALID/READY)
//   S_AXI_R*            read data channel (ID/DATA/RESP/LAST, VALID/READY)
//
// Optional build macro AXI_MEM_SLAVE_STALL_EN: an LFSR randomly gates the
// address/data READY outputs and delays response entry by one cycle.
module axi_mem_slave #(
    parameter int                ID_W      = 1,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 64,
    parameter int                MEM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     S_AXI_AWID,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic [7:0]          S_AXI_AWLEN,
    input  logic [2:0]          S_AXI_AWSIZE,
    input  logic [1:0]          S_AXI_AWBURST,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WLAST,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [ID_W-1:0]     S_AXI_BID,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ID_W-1:0]     S_AXI_ARID,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic [7:0]          S_AXI_ARLEN,
    input  logic [2:0]          S_AXI_ARSIZE,
    input  logic [1:0]          S_AXI_ARBURST,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [ID_W-1:0]     S_AXI_RID,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RLAST,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int BSHIFT = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_HOLD, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // Whole-burst legality, evaluated once at address accept. The last beat
    // index is computed one bit wider so a burst running off the top of the
    // address space cannot wrap back into range; addresses below BASE_ADDR
    // wrap to huge indices and land in DECERR as well.
    function automatic logic [1:0] check_burst(input logic [ADDR_W-1:0] addr,
                                               input logic [7:0]        len,
                                               input logic [2:0]        size,
                                               input logic [1:0]        burst);
        logic [ADDR_W-1:0] idx;
        logic [ADDR_W:0]   last;
        idx  = (addr - BASE_ADDR) >> BSHIFT;
        last = {1'b0, idx} + ((burst == BURST_INCR) ? {{(ADDR_W-7){1'b0}}, len}
                                                    : {(ADDR_W+1){1'b0}});
        if (size != 3'(BSHIFT) || burst[1])
            return RESP_SLVERR;
        else if (last >= (ADDR_W+1)'(MEM_WORDS))
            return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> BSHIFT);
    endfunction

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic gate_aw, gate_w, gate_ar, stall;
`ifdef AXI_MEM_SLAVE_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign gate_aw = lfsr[0];
    assign gate_w  = lfsr[1];
    assign gate_ar = lfsr[2];
    assign stall   = lfsr[3];
`else
    assign gate_aw = 1'b1;
    assign gate_w  = 1'b1;
    assign gate_ar = 1'b1;
    assign stall   = 1'b0;
`endif

    // ---------------- write side ----------------
    w_state_t          w_state;
    logic              aw_rdy_q, w_rdy_q;
    logic [IDX_W-1:0]  wr_idx;
    logic [7:0]        wr_len, wr_beat;
    logic [1:0]        wr_resp;
    logic              wr_incr, wr_err;
    logic              aw_hs, w_hs, beat_bad, mem_we;

    assign S_AXI_AWREADY = aw_rdy_q & gate_aw;
    assign S_AXI_WREADY  = w_rdy_q & gate_w;
    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    // WLAST must coincide exactly with beat AWLEN.
    assign beat_bad = S_AXI_WLAST ? (wr_beat != wr_len) : (wr_beat == wr_len);
    // Once a burst has overrun its length, later beats are dropped; the
    // offending beat itself (and everything before it) is still written.
    assign mem_we = w_hs && (w_state == W_DATA) && (wr_resp == RESP_OKAY) && !wr_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++)
                if (S_AXI_WSTRB[b]) mem[wr_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state      <= W_IDLE;
            aw_rdy_q     <= 1'b0;
            w_rdy_q      <= 1'b0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            S_AXI_BID    <= '0;
            wr_idx       <= '0;
            wr_len       <= '0;
            wr_beat      <= '0;
            wr_resp      <= RESP_OKAY;
            wr_incr      <= 1'b0;
            wr_err       <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_rdy_q  <= 1'b0;
                        w_rdy_q   <= 1'b1;
                        S_AXI_BID <= S_AXI_AWID;
                        wr_idx    <= word_index(S_AXI_AWADDR);
                        wr_len    <= S_AXI_AWLEN;
                        wr_resp   <= check_burst(S_AXI_AWADDR, S_AXI_AWLEN,
                                                 S_AXI_AWSIZE, S_AXI_AWBURST);
                        wr_incr   <= (S_AXI_AWBURST == BURST_INCR);
                        wr_beat   <= '0;
                        wr_err    <= 1'b0;
                        w_state   <= W_DATA;
                    end else begin
                        aw_rdy_q  <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_beat <= wr_beat + 8'd1;
                        if (wr_incr) wr_idx <= wr_idx + IDX_W'(1);
                        if (beat_bad) wr_err <= 1'b1;
                        if (S_AXI_WLAST) begin
                            w_rdy_q     <= 1'b0;
                            S_AXI_BRESP <= (wr_resp != RESP_OKAY) ? wr_resp :
                                           ((wr_err || beat_bad) ? RESP_SLVERR : RESP_OKAY);
                            if (stall) begin
                                w_state <= W_HOLD;
                            end else begin
                                S_AXI_BVALID <= 1'b1;
                                w_state      <= W_RESP;
                            end
                        end
                    end
                end
                W_HOLD: begin
                    S_AXI_BVALID <= 1'b1;
                    w_state      <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        aw_rdy_q     <= 1'b1;
                        w_state      <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read side ----------------
    // rd_idx always holds the RAM index of the next beat to fetch.
    r_state_t          r_state;
    logic              ar_rdy_q, ar_hs, r_hs, rd_incr, rd_wait;
    logic [IDX_W-1:0]  rd_idx;
    logic [7:0]        rd_len, rd_beat;

    assign S_AXI_ARREADY = ar_rdy_q & gate_ar;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
    assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= R_IDLE;
            ar_rdy_q     <= 1'b0;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RLAST  <= 1'b0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RID    <= '0;
            S_AXI_RDATA  <= '0;
            rd_idx       <= '0;
            rd_len       <= '0;
            rd_beat      <= '0;
            rd_incr      <= 1'b0;
            rd_wait      <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_rdy_q    <= 1'b0;
                        S_AXI_RID   <= S_AXI_ARID;
                        S_AXI_RRESP <= check_burst(S_AXI_ARADDR, S_AXI_ARLEN,
                                                   S_AXI_ARSIZE, S_AXI_ARBURST);
                        rd_idx      <= word_index(S_AXI_ARADDR);
                        rd_len      <= S_AXI_ARLEN;
                        rd_incr     <= (S_AXI_ARBURST == BURST_INCR);
                        rd_beat     <= '0;
                        rd_wait     <= 1'b0;
                        r_state     <= R_FETCH;
                    end else begin
                        ar_rdy_q    <= 1'b1;
                    end
                end
                R_FETCH: begin
                    if (stall && !rd_wait) begin
                        rd_wait <= 1'b1;
                    end else begin
                        S_AXI_RDATA  <= (S_AXI_RRESP == RESP_OKAY) ? mem[rd_idx] : '0;
                        S_AXI_RLAST  <= (rd_len == 8'd0);
                        S_AXI_RVALID <= 1'b1;
                        if (rd_incr) rd_idx <= rd_idx + IDX_W'(1);
                        r_state      <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (S_AXI_RLAST) begin
                            S_AXI_RVALID <= 1'b0;
                            S_AXI_RLAST  <= 1'b0;
                            ar_rdy_q     <= 1'b1;
                            r_state      <= R_IDLE;
                        end else begin
                            S_AXI_RDATA <= (S_AXI_RRESP == RESP_OKAY) ? mem[rd_idx] : '0;
                            S_AXI_RLAST <= ((rd_beat + 8'd1) == rd_len);
                            rd_beat     <= rd_beat + 8'd1;
                            if (rd_incr) rd_idx <= rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - directed table-driven bench for axi_mem_slave
module tb_axi_mem_slave;

    localparam int          ID_W   = 1;
    localparam int          ADDR_W = 32;
    localparam int          DATA_W = 64;
    localparam int          MEMW   = 4096;
    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam int          LIMIT  = 200;

    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ID_W-1:0] awid = '0, arid = '0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0;
    logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, rlast;
    logic [ID_W-1:0] bid, rid;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_mem_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .MEM_WORDS(MEMW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen),
        .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
        .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    typedef logic [7:0][63:0] beats_t;

    typedef struct {
        bit          wr;
        logic        id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  strb;
        beats_t      d;     // write data, or expected read data
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic beats_t b4(input logic [63:0] d0, d1, d2, d3);
        beats_t r;
        r = '0;
        r[0] = d0; r[1] = d1; r[2] = d2; r[3] = d3;
        return r;
    endfunction

    function automatic beats_t seq8(input logic [63:0] base);
        beats_t r;
        for (int i = 0; i < 8; i++) r[i] = base + 64'(i);
        return r;
    endfunction

    function automatic vec_t mkv(input bit wr, input logic id, input logic [31:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst, input logic [7:0] strb,
                                 input beats_t d, input logic [1:0] resp);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.size = size;
        v.burst = burst; v.strb = strb; v.d = d; v.resp = resp;
        return v;
    endfunction

    task automatic do_write(input logic id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [7:0] strb, input beats_t wd, input int last_at,
                            input logic [1:0] exp_resp, input string name);
        int t;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        t = 0;
        while (!awready && t < LIMIT) begin @(negedge clk); t++; end
        check({name, "_aw_wait"}, 64'(t < LIMIT), 64'd1);
        @(negedge clk);
        awvalid = 1'b0;
        check({name, "_wready_t1"}, 64'(wready), 64'd1);
        for (int b = 0; b <= last_at; b++) begin
            wvalid = 1'b1; wdata = wd[b]; wstrb = strb; wlast = (b == last_at);
            t = 0;
            while (!wready && t < LIMIT) begin @(negedge clk); t++; end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        check({name, "_bvalid_u1"}, 64'(bvalid), 64'd1);
        check({name, "_bresp"}, 64'(bresp), 64'(exp_resp));
        check({name, "_bid"}, 64'(bid), 64'(id));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check({name, "_bvalid_done"}, 64'(bvalid), 64'd0);
    endtask

    task automatic do_read(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                           input logic [1:0] exp_resp, input beats_t exp_d, input string name);
        int t, beat, k;
        bit held;
        logic [63:0] hd;
        logic hl;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        t = 0;
        while (!arready && t < LIMIT) begin @(negedge clk); t++; end
        check({name, "_ar_wait"}, 64'(t < LIMIT), 64'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check({name, "_rvalid_t1"}, 64'(rvalid), 64'd0);
        @(negedge clk);
        check({name, "_rvalid_t2"}, 64'(rvalid), 64'd1);
        beat = 0; k = 0; held = 0; hd = '0; hl = 1'b0;
        while (beat <= int'(len) && k < 4 * LIMIT) begin
            rready = toggle ? (k % 2 == 0) : 1'b1;
            if (rvalid) begin
                if (held) begin
                    check($sformatf("%s_hold_data%0d", name, beat), rdata, hd);
                    check($sformatf("%s_hold_last%0d", name, beat), 64'(rlast), 64'(hl));
                end
                if (rready) begin
                    check($sformatf("%s_data%0d", name, beat), rdata, exp_d[beat]);
                    check($sformatf("%s_resp%0d", name, beat), 64'(rresp), 64'(exp_resp));
                    check($sformatf("%s_last%0d", name, beat), 64'(rlast), 64'(beat == int'(len)));
                    check($sformatf("%s_rid%0d", name, beat), 64'(rid), 64'(id));
                    beat++;
                    held = 0;
                end else begin
                    held = 1; hd = rdata; hl = rlast;
                end
            end
            @(negedge clk);
            k++;
        end
        rready = 1'b0;
        check({name, "_beats"}, 64'(beat), 64'(int'(len) + 1));
        check({name, "_rvalid_done"}, 64'(rvalid), 64'd0);
    endtask

    initial begin : main
        int bt;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_wready",  64'(wready),  64'd0);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_rlast",   64'(rlast),   64'd0);
        check("rst_resps",   64'({bresp, rresp, bid, rid}), 64'd0);
        check("rst_rdata",   rdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_awready", 64'(awready), 64'd1);
        check("post_rst_arready", 64'(arready), 64'd1);

        vecs.push_back(mkv(1, 0, BASE + 32'h40, 3, 3, INCR, 8'hFF,
            b4(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444), OKAY));
        vecs.push_back(mkv(0, 1, BASE + 32'h40, 3, 3, INCR, 8'h00,
            b4(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444), OKAY));
        vecs.push_back(mkv(1, 1, BASE + 32'h100, 0, 3, INCR, 8'hFF,
            b4(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0), OKAY));
        vecs.push_back(mkv(1, 0, BASE + 32'h100, 0, 3, INCR, 8'h0F,
            b4(64'hAAAA_AAAA_BBBB_BBBB, 0, 0, 0), OKAY));
        vecs.push_back(mkv(0, 0, BASE + 32'h100, 0, 3, INCR, 8'h00,
            b4(64'hFFFF_FFFF_BBBB_BBBB, 0, 0, 0), OKAY));
        vecs.push_back(mkv(1, 1, BASE + 32'h200, 2, 3, FIXED, 8'hFF,
            b4(64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
               64'h7777_7777_7777_7777, 0), OKAY));
        vecs.push_back(mkv(0, 1, BASE + 32'h200, 1, 3, FIXED, 8'h00,
            b4(64'h7777_7777_7777_7777, 64'h7777_7777_7777_7777, 0, 0), OKAY));
        // Top word of RAM, then out-of-range bursts touching it
        vecs.push_back(mkv(1, 0, BASE + MEMW*8 - 8, 0, 3, INCR, 8'hFF,
            b4(64'h0123_4567_89AB_CDEF, 0, 0, 0), OKAY));
        vecs.push_back(mkv(1, 1, BASE + MEMW*8 - 8, 1, 3, INCR, 8'hFF,
            b4(64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999, 0, 0), DECERR));
        vecs.push_back(mkv(0, 0, BASE + MEMW*8 - 8, 1, 3, INCR, 8'h00,
            b4(0, 0, 0, 0), DECERR));
        vecs.push_back(mkv(0, 1, BASE + MEMW*8 - 8, 0, 3, INCR, 8'h00,
            b4(64'h0123_4567_89AB_CDEF, 0, 0, 0), OKAY));
        vecs.push_back(mkv(0, 0, BASE - 8, 0, 3, INCR, 8'h00, b4(0, 0, 0, 0), DECERR));
        // Illegal size / burst type
        vecs.push_back(mkv(1, 0, BASE + 32'h40, 0, 2, INCR, 8'hFF,
            b4(64'hDEAD_DEAD_DEAD_DEAD, 0, 0, 0), SLVERR));
        vecs.push_back(mkv(1, 1, BASE + 32'h48, 0, 3, RSVD, 8'hFF,
            b4(64'hDEAD_DEAD_DEAD_DEAD, 0, 0, 0), SLVERR));
        vecs.push_back(mkv(1, 0, BASE + 32'h50, 0, 3, WRAP, 8'hFF,
            b4(64'hDEAD_DEAD_DEAD_DEAD, 0, 0, 0), SLVERR));
        vecs.push_back(mkv(0, 1, BASE + 32'h40, 3, 3, INCR, 8'h00,
            b4(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444), OKAY));
        vecs.push_back(mkv(0, 0, BASE + 32'h40, 0, 2, INCR, 8'h00, b4(0, 0, 0, 0), SLVERR));
        // SLVERR wins over DECERR
        vecs.push_back(mkv(0, 1, BASE + MEMW*8 - 8, 1, 2, INCR, 8'h00, b4(0, 0, 0, 0), SLVERR));
        // Setup for hand sequences
        vecs.push_back(mkv(1, 0, BASE + 32'h300, 3, 3, INCR, 8'hFF,
            b4(64'hC0C0_C0C0_C0C0_C0C0, 64'hC1C1_C1C1_C1C1_C1C1,
               64'hC2C2_C2C2_C2C2_C2C2, 64'hC3C3_C3C3_C3C3_C3C3), OKAY));
        vecs.push_back(mkv(1, 1, BASE + 32'h400, 7, 3, INCR, 8'hFF,
            seq8(64'h0400_0000_0000_0000), OKAY));

        foreach (vecs[i]) begin
            if (vecs[i].wr)
                do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                         vecs[i].strb, vecs[i].d, int'(vecs[i].len), vecs[i].resp,
                         $sformatf("vec%0d", i));
            else
                do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                        1'b0, vecs[i].resp, vecs[i].d, $sformatf("vec%0d", i));
        end

        // Early WLAST on beat 1 of a LEN=3 burst: beats 0-1 land, 2-3 untouched
        do_write(1, BASE + 32'h300, 3, 3, INCR, 8'hFF,
                 b4(64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
                    64'hA2A2_A2A2_A2A2_A2A2, 64'hA3A3_A3A3_A3A3_A3A3), 1, SLVERR, "early_wlast");
        do_read(0, BASE + 32'h300, 3, 3, INCR, 1'b0, OKAY,
                b4(64'hA0A0_A0A0_A0A0_A0A0, 64'hA1A1_A1A1_A1A1_A1A1,
                   64'hC2C2_C2C2_C2C2_C2C2, 64'hC3C3_C3C3_C3C3_C3C3), "early_rd");

        // LEN=7 read with toggling RREADY while a write runs elsewhere
        fork
            do_read(1, BASE + 32'h400, 7, 3, INCR, 1'b1, OKAY,
                    seq8(64'h0400_0000_0000_0000), "toggle_rd");
            do_write(0, BASE + 32'h800, 1, 3, INCR, 8'hFF,
                     b4(64'h0800_0000_0000_00AA, 64'h0800_0000_0000_00BB, 0, 0),
                     1, OKAY, "conc_wr");
        join
        do_read(0, BASE + 32'h800, 1, 3, INCR, 1'b0, OKAY,
                b4(64'h0800_0000_0000_00AA, 64'h0800_0000_0000_00BB, 0, 0), "conc_rd");

        // Reset while beat 2 of a LEN=7 read is on the bus
        @(negedge clk);
        arid = 1'b1; araddr = BASE + 32'h400; arlen = 7; arsize = 3; arburst = INCR;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        bt = 0;
        for (int k = 0; k < 20 && bt < 2; k++) begin
            @(negedge clk);
            if (rvalid) begin
                check($sformatf("rst_seq_data%0d", bt), rdata, 64'h0400_0000_0000_0000 + 64'(bt));
                bt++;
            end
        end
        @(negedge clk);
        check("rst_seq_beat2_valid", 64'(rvalid), 64'd1);
        rst = 1'b1; rready = 1'b0;
        @(negedge clk);
        check("rst_seq_rvalid", 64'(rvalid), 64'd0);
        check("rst_seq_arready_in_rst", 64'(arready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_seq_arready", 64'(arready), 64'd1);
        check("rst_seq_awready", 64'(awready), 64'd1);
        check("rst_seq_rvalid_idle", 64'(rvalid), 64'd0);
        do_read(0, BASE + 32'h400, 7, 3, INCR, 1'b0, OKAY,
                seq8(64'h0400_0000_0000_0000), "after_rst_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
